// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rr_arbiter
// Description : Common-data-bus arbiter and broadcaster. Grants one result
//               source per cycle (round-robin or fixed priority) and drives
//               a registered CDB beat. Wide results are sent as two
//               back-to-back beats (low word, then high word) with the bus
//               locked in between.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
    parameter int N_SRC = 6,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int RR_EN = 1,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC-1:0]        src_wide,
    input  logic [N_SRC*XLEN-1:0]   src_data_lo,
    input  logic [N_SRC*XLEN-1:0]   src_data_hi,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_data,
    output logic                    cdb_hi,
    output logic [SRC_W-1:0]        cdb_src,
    output logic                    busy_hi
);

    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_SRC - 1);

    typedef enum logic [0:0] {
        ST_ARB     = 1'b0,
        ST_HOLD_HI = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0]    hold_data_q, hold_data_d;
    logic [TAG_W-1:0]   hold_tag_q, hold_tag_d;
    logic [SRC_W-1:0]   hold_src_q, hold_src_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]    cdb_data_q, cdb_data_d;
    logic               cdb_hi_q, cdb_hi_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic [SRC_W-1:0]   search_idx;
    logic [SRC_W-1:0]   win_idx;
    logic               win_found;
    logic               arb_en;
    logic [N_SRC-1:0]   grant_oh;
    logic               grant_any;
    logic [XLEN-1:0]    sel_lo;
    logic [XLEN-1:0]    sel_hi;
    logic [TAG_W-1:0]   sel_tag;
    logic               sel_wide;

    // Winner search: first valid index at/after the pointer (wrapping), or lowest index in fixed-priority mode
    always_comb begin
        search_idx = (RR_EN != 0) ? ptr_q : '0;
        win_idx    = '0;
        win_found  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!win_found && src_valid[search_idx]) begin
                win_found = 1'b1;
                win_idx   = search_idx;
            end
            search_idx = (search_idx == LAST_IDX) ? '0 : search_idx + 1'b1;
        end
    end

    // Grant is suppressed during reset, flush and while the high beat is pending
    always_comb begin
        arb_en   = (state_q == ST_ARB) && !flush && !rst;
        grant_oh = '0;
        if (arb_en && win_found) begin
            grant_oh[win_idx] = 1'b1;
        end
    end

    assign grant_any = |grant_oh;
    assign src_ready = grant_oh;

    // One-hot mux of the granted source's payload
    always_comb begin
        sel_lo   = '0;
        sel_hi   = '0;
        sel_tag  = '0;
        sel_wide = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_oh[i]) begin
                sel_lo   = src_data_lo[i*XLEN +: XLEN];
                sel_hi   = src_data_hi[i*XLEN +: XLEN];
                sel_tag  = src_tag[i*TAG_W +: TAG_W];
                sel_wide = src_wide[i];
            end
        end
    end

    // Next-state and next-beat selection; flush outranks everything, then the pending high beat, then a new grant
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_data_d = hold_data_q;
        hold_tag_d  = hold_tag_q;
        hold_src_d  = hold_src_q;
        cdb_valid_d = 1'b0;
        cdb_hi_d    = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;

        if (flush) begin
            state_d = ST_ARB;
        end else if (state_q == ST_HOLD_HI) begin
            cdb_valid_d = 1'b1;
            cdb_hi_d    = 1'b1;
            cdb_data_d  = hold_data_q;
            cdb_tag_d   = hold_tag_q;
            cdb_src_d   = hold_src_q;
            state_d     = ST_ARB;
        end else if (grant_any) begin
            cdb_valid_d = 1'b1;
            cdb_data_d  = sel_lo;
            cdb_tag_d   = sel_tag;
            cdb_src_d   = win_idx;
            if (RR_EN != 0) begin
                ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
            if (sel_wide) begin
                hold_data_d = sel_hi;
                hold_tag_d  = sel_tag;
                hold_src_d  = win_idx;
                state_d     = ST_HOLD_HI;
            end
        end
    end

    // State, pointer, holding register and CDB beat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            hold_data_q <= '0;
            hold_tag_q  <= '0;
            hold_src_q  <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_hi_q    <= 1'b0;
            cdb_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_data_q <= hold_data_d;
            hold_tag_q  <= hold_tag_d;
            hold_src_q  <= hold_src_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_hi_q    <= cdb_hi_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_hi    = cdb_hi_q;
    assign cdb_src   = cdb_src_q;
    assign busy_hi   = (state_q == ST_HOLD_HI);

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_rr_arbiter
// Description : Self-checking bench for cdb_rr_arbiter: a round-robin
//               instance checked every cycle against a behavioural model,
//               plus a fixed-priority instance for directed priority checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_rr_arbiter;

    localparam int N  = 6;
    localparam int XL = 32;
    localparam int TW = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic            flush = 1'b0;
    logic [N-1:0]    src_valid = '0, src_ready, src_wide = '0;
    logic [N*XL-1:0] src_data_lo = '0, src_data_hi = '0;
    logic [N*TW-1:0] src_tag = '0;
    logic            cdb_valid, cdb_hi, busy_hi;
    logic [TW-1:0]   cdb_tag;
    logic [XL-1:0]   cdb_data;
    logic [SW-1:0]   cdb_src;

    // Fixed-priority instance signals
    logic            fp_flush = 1'b0;
    logic [N-1:0]    fp_valid = '0, fp_ready, fp_wide = '0;
    logic [N*XL-1:0] fp_lo = '0, fp_hi = '0;
    logic [N*TW-1:0] fp_tag = '0;
    logic            fp_cdb_valid, fp_cdb_hi, fp_busy_hi;
    logic [TW-1:0]   fp_cdb_tag;
    logic [XL-1:0]   fp_cdb_data;
    logic [SW-1:0]   fp_cdb_src;

    cdb_rr_arbiter #(.N_SRC(N), .XLEN(XL), .TAG_W(TW), .RR_EN(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready), .src_wide(src_wide),
        .src_data_lo(src_data_lo), .src_data_hi(src_data_hi), .src_tag(src_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_hi(cdb_hi), .cdb_src(cdb_src), .busy_hi(busy_hi)
    );

    cdb_rr_arbiter #(.N_SRC(N), .XLEN(XL), .TAG_W(TW), .RR_EN(0)) u_fp (
        .clk(clk), .rst(rst), .flush(fp_flush),
        .src_valid(fp_valid), .src_ready(fp_ready), .src_wide(fp_wide),
        .src_data_lo(fp_lo), .src_data_hi(fp_hi), .src_tag(fp_tag),
        .cdb_valid(fp_cdb_valid), .cdb_tag(fp_cdb_tag), .cdb_data(fp_cdb_data),
        .cdb_hi(fp_cdb_hi), .cdb_src(fp_cdb_src), .busy_hi(fp_busy_hi)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the round-robin instance
    int            m_ptr;
    bit            m_hold;
    logic [XL-1:0] m_hd;
    logic [TW-1:0] m_ht;
    int            m_hs;
    logic          e_valid, e_hi;
    logic [XL-1:0] e_data;
    logic [TW-1:0] e_tag;
    int            e_src;
    logic [N-1:0]  m_acc;
    logic [N-1:0]  r_seen;

    // Hooks for fixed-priority checks done inside cycle()
    bit            fp_on = 1'b0;
    logic [N-1:0]  fp_exp_rdy;
    int            fp_exp_src;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_hold = 1'b0; m_hd = '0; m_ht = '0; m_hs = 0;
        e_valid = 1'b0; e_hi = 1'b0; e_data = '0; e_tag = '0; e_src = 0;
        m_acc = '0;
    endtask

    // Evaluate one clock of the model from the currently applied inputs
    task automatic model_step();
        int g;
        logic [N-1:0] exp_rdy;
        g = -1;
        if (!flush && !m_hold) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && src_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", {58'd0, src_ready}, {58'd0, exp_rdy});
        chk("busy_hi", {63'd0, busy_hi}, {63'd0, m_hold});
        m_acc = exp_rdy & src_valid;
        if (flush) begin
            e_valid = 1'b0; e_hi = 1'b0; m_hold = 1'b0;
        end else if (m_hold) begin
            e_valid = 1'b1; e_hi = 1'b1; e_data = m_hd; e_tag = m_ht; e_src = m_hs;
            m_hold = 1'b0;
        end else if (g >= 0) begin
            e_valid = 1'b1; e_hi = 1'b0;
            e_data = src_data_lo[g*XL +: XL];
            e_tag  = src_tag[g*TW +: TW];
            e_src  = g;
            m_ptr  = (g + 1) % N;
            if (src_wide[g]) begin
                m_hold = 1'b1; m_hd = src_data_hi[g*XL +: XL]; m_ht = e_tag; m_hs = g;
            end
        end else begin
            e_valid = 1'b0; e_hi = 1'b0;
        end
    endtask

    // One clock: combinational checks at negedge, CDB checks 1 time unit after posedge
    task automatic cycle();
        @(negedge clk);
        r_seen = src_ready;
        model_step();
        if (fp_on) chk("fp_ready", {58'd0, fp_ready}, {58'd0, fp_exp_rdy});
        @(posedge clk);
        #1;
        chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, e_valid});
        chk("cdb_hi", {63'd0, cdb_hi}, {63'd0, e_hi});
        chk("cdb_data", {32'd0, cdb_data}, {32'd0, e_data});
        chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, e_tag});
        chk("cdb_src", {61'd0, cdb_src}, 64'(e_src));
        if (fp_on) begin
            chk("fp_cdb_valid", {63'd0, fp_cdb_valid}, 64'd1);
            chk("fp_cdb_src", {61'd0, fp_cdb_src}, 64'(fp_exp_src));
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rst_tag", {60'd0, cdb_tag}, 64'd0);
        chk("rst_data", {32'd0, cdb_data}, 64'd0);
        chk("rst_hi", {63'd0, cdb_hi}, 64'd0);
        chk("rst_src", {61'd0, cdb_src}, 64'd0);
        chk("rst_busy", {63'd0, busy_hi}, 64'd0);
        chk("rst_ready", {58'd0, src_ready}, 64'd0);
        chk("rst_fp_valid", {63'd0, fp_cdb_valid}, 64'd0);
        chk("rst_fp_ready", {58'd0, fp_ready}, 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fixed priority: index 3 wins over 5 until it drops
        fp_tag[3*TW +: TW] = 4'd3;
        fp_tag[5*TW +: TW] = 4'd5;
        fp_valid   = 6'b101000;
        fp_exp_rdy = 6'b001000;
        fp_exp_src = 3;
        fp_on      = 1'b1;
        repeat (4) cycle();
        fp_valid   = 6'b100000;
        fp_exp_rdy = 6'b100000;
        fp_exp_src = 5;
        cycle();
        fp_on    = 1'b0;
        fp_valid = '0;
        cycle();

        // Reset mid-operation with all sources valid
        for (int i = 0; i < N; i++) begin
            src_tag[i*TW +: TW]     = TW'(i + 1);
            src_data_lo[i*XL +: XL] = XL'(32'h100 + i);
        end
        src_wide  = '0;
        src_valid = 6'b111111;
        cycle();
        cycle();
        do_reset();

        // Round robin from index 0: tags 1..6 then back to index 0
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk("rr_tag", {60'd0, cdb_tag}, 64'((k % 6) + 1));
            chk("rr_src", {61'd0, cdb_src}, 64'(k % 6));
        end
        src_valid = '0;
        cycle();

        // Wide result from source 3 with source 0 also waiting
        src_valid = 6'b001001;
        src_wide  = 6'b001000;
        src_data_lo[3*XL +: XL] = 32'h0000_1111;
        src_data_hi[3*XL +: XL] = 32'hDEAD_BEEF;
        src_tag[3*TW +: TW]     = 4'd7;
        src_data_lo[0*XL +: XL] = 32'h0000_AAAA;
        src_tag[0*TW +: TW]     = 4'd9;
        cycle();
        chk("wide_lo_data", {32'd0, cdb_data}, 64'h1111);
        chk("wide_lo_hi", {63'd0, cdb_hi}, 64'd0);
        chk("wide_busy", {63'd0, busy_hi}, 64'd1);
        src_valid[3] = 1'b0;
        cycle();
        chk("wide_hold_ready", {58'd0, r_seen}, 64'd0);
        chk("wide_hi_data", {32'd0, cdb_data}, 64'hDEAD_BEEF);
        chk("wide_hi_tag", {60'd0, cdb_tag}, 64'd7);
        chk("wide_hi_flag", {63'd0, cdb_hi}, 64'd1);
        cycle();
        chk("wide_next_src", {61'd0, cdb_src}, 64'd0);
        chk("wide_next_data", {32'd0, cdb_data}, 64'hAAAA);
        src_valid = '0;
        src_wide  = '0;

        // Flush during the pending high beat
        src_valid = 6'b000100;
        src_wide  = 6'b000100;
        src_data_lo[2*XL +: XL] = 32'h2222;
        src_data_hi[2*XL +: XL] = 32'h3333;
        src_tag[2*TW +: TW]     = 4'd5;
        cycle();
        chk("flush_lo", {32'd0, cdb_data}, 64'h2222);
        src_valid = '0;
        src_wide  = '0;
        flush     = 1'b1;
        cycle();
        chk("flush_ready", {58'd0, r_seen}, 64'd0);
        chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
        chk("flush_busy", {63'd0, busy_hi}, 64'd0);
        flush = 1'b0;
        src_valid = 6'b000010;
        src_data_lo[1*XL +: XL] = 32'h66;
        src_tag[1*TW +: TW]     = 4'd6;
        cycle();
        chk("post_flush_src", {61'd0, cdb_src}, 64'd1);
        chk("post_flush_data", {32'd0, cdb_data}, 64'h66);

        // Idle after a broadcast: data and tag hold
        src_valid = 6'b010000;
        src_data_lo[4*XL +: XL] = 32'h55;
        src_tag[4*TW +: TW]     = 4'd2;
        cycle();
        src_valid = '0;
        repeat (4) begin
            cycle();
            chk("idle_valid", {63'd0, cdb_valid}, 64'd0);
            chk("idle_data", {32'd0, cdb_data}, 64'h55);
            chk("idle_tag", {60'd0, cdb_tag}, 64'd2);
            chk("idle_ready", {58'd0, r_seen}, 64'd0);
        end

        // Randomised traffic with occasional flush, checked against the model
        m_acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] || m_acc[i]) begin
                    src_valid[i] = ($urandom_range(0, 9) < 6);
                    src_wide[i]  = ($urandom_range(0, 3) == 0);
                    src_data_lo[i*XL +: XL] = $urandom();
                    src_data_hi[i*XL +: XL] = $urandom();
                    src_tag[i*TW +: TW]     = TW'($urandom_range(0, 15));
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
